// File: rtl/mips_bus_pkg.sv
// =============================================================================
// mips_bus_pkg : shared FSM encoding, control-register offsets and width helper
// Rev 1.0
// =============================================================================
`default_nettype none

package mips_bus_pkg;

  typedef logic [1:0] bridge_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned REG_IMASK  = 0;
  localparam int unsigned REG_IPEND  = 1;
  localparam int unsigned REG_STATUS = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_irq_agg.sv
// =============================================================================
// mips_irq_agg : interrupt pending/mask registers feeding hwint[7:2]
// Rev 1.0 - edge capture when BRIDGE_EDGE_IRQ_EN is defined, level otherwise
// =============================================================================
`default_nettype none

module mips_irq_agg #(
  parameter int NDEV = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDEV-1:0] dev_irq_i,
  input  logic            imask_we_i,
  input  logic [NDEV-1:0] imask_wdata_i,
  input  logic [NDEV-1:0] ipend_clr_i,
  output logic [NDEV-1:0] imask_o,
  output logic [NDEV-1:0] ipend_o,
  output logic [5:0]      hwint_o
);

  logic [NDEV-1:0] imask_q, imask_d;
  logic [NDEV-1:0] ipend_q, ipend_d;
  logic [5:0]      hwint_q, hwint_d;

`ifdef BRIDGE_EDGE_IRQ_EN
  logic [NDEV-1:0] irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= '0;
    else     irq_q <= dev_irq_i;
  end

  // A new edge wins over a clear landing on the same bit.
  assign ipend_d = (ipend_q & ~ipend_clr_i) | (dev_irq_i & ~irq_q);
`else
  logic unused_clr;
  assign unused_clr = ^ipend_clr_i;
  assign ipend_d    = dev_irq_i;
`endif

  assign imask_d = imask_we_i ? imask_wdata_i : imask_q;

  for (genvar i = 0; i < 6; i++) begin : g_hwint
    if (i < NDEV) begin : g_used
      assign hwint_d[i] = ipend_q[i] & imask_q[i];
    end else begin : g_tied
      assign hwint_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imask_q <= '0;
      ipend_q <= '0;
      hwint_q <= '0;
    end else begin
      imask_q <= imask_d;
      ipend_q <= ipend_d;
      hwint_q <= hwint_d;
    end
  end

  assign imask_o = imask_q;
  assign ipend_o = ipend_q;
  assign hwint_o = hwint_q;

endmodule

`default_nettype wire

// File: rtl/mips_sys_bridge.sv
// =============================================================================
// mips_sys_bridge : MIPS MMIO bus to NDEV peripheral slots with timeout and IRQs
// Rev 1.0 - interrupt capture mode selected by BRIDGE_EDGE_IRQ_EN
// =============================================================================
`default_nettype none

module mips_sys_bridge
  import mips_bus_pkg::*;
#(
  parameter int          NDEV      = 6,
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter int          WIN_WORDS = 4,
  parameter int          TMO_CYC   = 15,
  localparam int         DAW       = (clog2(WIN_WORDS) == 0) ? 1 : clog2(WIN_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req_i,
  input  logic [29:0]      cpu_addr_i,
  input  logic             cpu_wen_i,
  input  logic [3:0]       cpu_be_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_ready_o,
  output logic             bus_err_o,
  output logic [NDEV-1:0]  dev_stb_o,
  output logic [DAW-1:0]   dev_addr_o,
  output logic             dev_wen_o,
  output logic [3:0]       dev_be_o,
  output logic [31:0]      dev_wdata_o,
  input  logic [32*NDEV-1:0] dev_rdata_i,
  input  logic [NDEV-1:0]  dev_ack_i,
  input  logic [NDEV-1:0]  dev_irq_i,
  output logic [5:0]       hwint_o
);

  localparam int          AW         = clog2(WIN_WORDS);
  localparam int          CTRL_WORDS = (WIN_WORDS < 4) ? 4 : WIN_WORDS;
  localparam logic [29:0] BASE_W     = DEV_BASE[31:2];
  localparam logic [29:0] DEV_SPAN   = 30'(NDEV * WIN_WORDS);
  localparam logic [29:0] CTRL_END   = 30'(NDEV * WIN_WORDS + CTRL_WORDS);
  localparam int          CW         = clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  bridge_state_t   state_q, state_d;
  logic [NDEV-1:0] stb_q, stb_d;
  logic [DAW-1:0]  addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            last_err_q, last_err_d;
  logic [2:0]      slot_q, slot_d;
  logic [2:0]      err_slot_q, err_slot_d;

  logic [29:0]     w_off, w_coff;
  logic            w_dev_hit, w_ctrl_hit, w_ctrl_we, w_ack_hit;
  logic [2:0]      w_slot;
  logic [NDEV-1:0] w_oh, w_imask, w_ipend, w_ipend_clr;
  logic [31:0]     w_ctrl_rdata, w_sel_rdata;

  // Unsigned wrap makes addresses below the base fall out as misses.
  assign w_off      = cpu_addr_i - BASE_W;
  assign w_coff     = w_off - DEV_SPAN;
  assign w_dev_hit  = w_off < DEV_SPAN;
  assign w_ctrl_hit = !w_dev_hit && (w_off < CTRL_END);
  assign w_slot     = 3'(w_off >> AW);

  for (genvar i = 0; i < NDEV; i++) begin : g_slot_oh
    assign w_oh[i] = w_dev_hit && (w_slot == 3'(i));
  end

  assign w_ctrl_we   = (state_q == ST_IDLE) && cpu_req_i && w_ctrl_hit && cpu_wen_i;
  assign w_ipend_clr = (w_ctrl_we && w_coff == 30'(REG_IPEND)) ? cpu_wdata_i[NDEV-1:0] : '0;
  assign w_ack_hit   = |(dev_ack_i & stb_q);

  always_comb begin
    w_ctrl_rdata = '0;
    if (w_coff == 30'(REG_IMASK))       w_ctrl_rdata[NDEV-1:0] = w_imask;
    else if (w_coff == 30'(REG_IPEND))  w_ctrl_rdata[NDEV-1:0] = w_ipend;
    else if (w_coff == 30'(REG_STATUS)) w_ctrl_rdata = {24'd0, 1'b0, err_slot_q, 3'd0, last_err_q};
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NDEV; i++)
      if (stb_q[i]) w_sel_rdata = dev_rdata_i[32*i +: 32];
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    last_err_d = last_err_q;
    slot_d     = slot_q;
    err_slot_d = err_slot_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_DONE;
          if (w_dev_hit) begin
            stb_d   = w_oh;
            addr_d  = (AW == 0) ? '0 : DAW'(w_off);
            wen_d   = cpu_wen_i;
            be_d    = cpu_be_i;
            wdata_d = cpu_wdata_i;
            cnt_d   = '0;
            slot_d  = w_slot;
            state_d = ST_ACCESS;
          end else if (w_ctrl_hit) begin
            if (!cpu_wen_i) rdata_d = w_ctrl_rdata;
            last_err_d = 1'b0;
          end else begin
            err_d      = 1'b1;
            last_err_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (w_ack_hit) begin
          rdata_d    = wen_q ? '0 : w_sel_rdata;
          stb_d      = '0;
          last_err_d = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          last_err_d = 1'b1;
          err_slot_d = slot_q;
          stb_d      = '0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stb_q      <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      last_err_q <= 1'b0;
      slot_q     <= '0;
      err_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
      slot_q     <= slot_d;
      err_slot_q <= err_slot_d;
    end
  end

  mips_irq_agg #(.NDEV(NDEV)) u_irq (
    .clk          (clk),
    .rst          (rst),
    .dev_irq_i    (dev_irq_i),
    .imask_we_i   (w_ctrl_we && w_coff == 30'(REG_IMASK)),
    .imask_wdata_i(cpu_wdata_i[NDEV-1:0]),
    .ipend_clr_i  (w_ipend_clr),
    .imask_o      (w_imask),
    .ipend_o      (w_ipend),
    .hwint_o      (hwint_o)
  );

  assign cpu_ready_o = (state_q == ST_DONE);
  assign bus_err_o   = (state_q == ST_DONE) && err_q;
  assign cpu_rdata_o = (state_q == ST_DONE) ? rdata_q : '0;
  assign dev_stb_o   = stb_q;
  assign dev_addr_o  = addr_q;
  assign dev_wen_o   = wen_q;
  assign dev_be_o    = be_q;
  assign dev_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: doc/mips_sys_bridge.md
Name: mips_sys_bridge

Overview:
- Parametrised system bridge between the multicycle MIPS core's memory-mapped I/O bus and NDEV peripherals.
- Decodes the device window, runs a req/ready handshake with per-device ack and timeout, and returns registered read data.
- Aggregates per-device interrupts through mask/pending registers into the core's hardware interrupt vector.
- Successor to the fixed 6-line HWInt arrangement: device count, window size and timeout are generalised, and the block adds wait states and an error response.

Parameters:
- NDEV, 6, number of device slots (1..6); slot i drives hwint bit i+2.
- DEV_BASE, 32'h0000_7F00, byte base of slot 0.
- WIN_WORDS, 4, words per slot window (power of 2); slot i base = DEV_BASE + i*WIN_WORDS*4.
- TMO_CYC, 15, max ACCESS cycles without ack before error (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  access request; held stable until cpu_ready.
- cpu_addr  in  30  word address [31:2].
- cpu_wen  in  1  1 = write.
- cpu_be  in  4  byte enables.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse with cpu_ready on decode miss or timeout.
- dev_stb  out  NDEV  one-hot strobe, held through ACCESS.
- dev_addr  out  log2(WIN_WORDS)  word offset in window.
- dev_wen  out  1  write qualifier.
- dev_be  out  4  byte enables.
- dev_wdata  out  32  write data.
- dev_rdata  in  32*NDEV  flattened; slot i = bits [32i+31:32i].
- dev_ack  in  NDEV  per-slot completion.
- dev_irq  in  NDEV  raw interrupt lines.
- hwint  out  6  [7:2] to core; bits above NDEV+1 tied 0.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; imask=0; ipend=0; timeout counter 0. Reset asserted mid-access aborts it immediately with no ready pulse.
- Control window at DEV_BASE + NDEV*WIN_WORDS*4:
  - word0 IMASK (R/W, NDEV bits, upper bits read 0).
  - word1 IPEND (read; write-1-to-clear, edge mode only).
  - word2 STATUS (read): [0] last access errored, [7:4] slot of last error.
  - Other words in the control window read 0 and ignore writes.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: when cpu_req=1, decode address.
    - Device slot hit: load dev_* outputs, raise dev_stb[i], clear the counter, go to ACCESS.
    - Control hit: perform the register access this cycle, go to DONE.
    - Miss: go to DONE with the error flag set.
  - ACCESS: when dev_ack[i]=1, capture slot rdata and go to DONE. Otherwise increment the counter; when counter == TMO_CYC-1 without ack, go to DONE with error and record the slot.
  - DONE: cpu_ready=1 for one cycle; bus_err per flag; dev_stb=0; cpu_rdata = captured value (0 on error or write). Return to IDLE.
- Latency from the cycle cpu_req is first sampled:
  - Control or miss: ready 1 cycle later.
  - Device: ready k+2 cycles later, where ack arrives k cycles after stb rises.
  - Timeout: ready TMO_CYC+1 cycles later.
- Back-to-back: a new request is accepted in IDLE on the cycle after DONE; there is no combinational path from cpu_req to cpu_ready.
- Acks on non-selected slots are ignored. An ack arriving after timeout is ignored.
- Interrupts: ipend[i] updated every cycle (mode below). hwint[i+2] = ipend[i] & imask[i], registered (1-cycle latency). Masking does not clear ipend.
- Simultaneous IPEND W1C and a new edge on the same bit: set wins.

Optional Feature:
- BRIDGE_EDGE_IRQ_EN defined: ipend[i] sets on a rising edge of dev_irq[i] (registered prior sample). It clears only by W1C to IPEND or reset.
- Not defined: level mode. ipend[i] = registered dev_irq[i]; IPEND writes are ignored and the device must deassert its own line.

Decomposition:
- Package mips_bus_pkg: FSM state enum, control register offsets (IMASK=0, IPEND=1, STATUS=2), and the clog2 helper for dev_addr width.
- One sub-module is natural: mips_irq_agg (ipend/imask/edge-detect/hwint registers, NDEV-parametrised). The decode, FSM and timeout counter stay in the top.

Test Plan:
- Read slot 2 offset 1 with NDEV=6 (addr 0x7F24), ack 3 cycles after stb, rdata 0x1234_5678 -> cpu_ready exactly 5 cycles after req, cpu_rdata=0x1234_5678, bus_err=0.
- Write slot 0 with no ack -> dev_stb[0] held 15 cycles, then cpu_ready+bus_err; STATUS reads 0x01. A late ack one cycle after that completion is ignored.
- Write IMASK=0x05, pulse dev_irq[0] and dev_irq[1] -> hwint=6'b000001 (bit2 only). Write IMASK=0x3F -> hwint=6'b000011.
- Edge mode: pending bit0 set; W1C IPEND=0x01 in the same cycle as a new edge on irq0 -> ipend[0] remains 1. W1C on the next cycle -> cleared.
- Access 0x7F80 (miss, NDEV=6) -> ready and bus_err 1 cycle after req, rdata=0, no dev_stb.
- Assert rst while in ACCESS -> dev_stb drops at once, no cpu_ready, imask=ipend=0, hwint=0.
